decode_issue: RTL and testbench
===============================

DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have parameter: FWD_EN, 1, enables writeback-to-decode bypass of the register file.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: instr_in  input  8  instruction byte {op[7:4], ra[3:2], rb[1:0]}, or immediate byte.
REQ-005 SHALL have port: instr_valid / instr_ready  input / output  1 / 1  fetch handshake; byte consumed when both high.
REQ-006 SHALL have port: wb_en, wb_addr, wb_data  input  1, 2, 8  register writeback from EXE.
REQ-007 SHALL have port: zn_in  input  2  ALU flags {Z, N}.
REQ-008 SHALL have port: op_out, s1_out, s2_out, imm_out  output  4, 8, 8, 8  ALU operands, registered.
REQ-009 SHALL have port: dst_out, wr_en_out, issue_valid  output  2, 1, 1  destination register, writeback request, issue strobe.
REQ-010 SHALL have port: br_taken, br_target  output  1, 8  branch redirect pulse and target address.

Function
REQ-011 SHALL hold four 8-bit registers R0..R3, written when wb_en=1 at the clock edge.
REQ-012 SHALL read s1=R[ra] and s2=R[rb]; if FWD_EN=1, wb_en=1 and wb_addr matches, SHALL use wb_data instead.
REQ-013 SHALL implement states DEC, IMM, FLAG_WAIT; reset state DEC.
REQ-014 DEC, accepted byte op=0xF (LOADIMM): latch dst=ra, go to IMM, no issue.
REQ-015 IMM: next accepted byte goes to imm_out, issue op=0xF with wr_en_out=1, return to DEC.
REQ-016 DEC, op in {1,2,3,4,5,7,8}: issue next cycle with wr_en_out=1, dst_out=ra; latency 1 cycle.
REQ-017 DEC, op in {6,0xE}: issue with wr_en_out=0; op=0: no issue, byte dropped.
REQ-018 op=9 (BR): br_taken=1 for one cycle, br_target=R[rb], no ALU issue.
REQ-019 op=0xA (BRZ) / 0xB (BRN): taken iff zn_in[1] / zn_in[0] is 1; not taken otherwise.
REQ-020 Conditional branch immediately after an issued op in {1..5}: SHALL enter FLAG_WAIT, deassert instr_ready one cycle, evaluate branch in next cycle.
REQ-021 instr_ready SHALL be 1 in DEC and IMM, 0 in FLAG_WAIT and in the cycle br_taken is asserted.
REQ-022 issue_valid and br_taken SHALL be single-cycle pulses and never high together.
REQ-023 Opcodes 0xC, 0xD SHALL be treated as op=0.
REQ-024 instr_valid=0 in any state SHALL hold state and issue nothing; IMM waits indefinitely.
REQ-025 Writeback and read to same register in the same cycle SHALL return new value when FWD_EN=1, old value when 0.

Reset
REQ-026 rst_n=0 SHALL immediately clear R0..R3, all outputs to 0, instr_ready to 0, state to DEC.
REQ-027 Reset mid-IMM SHALL discard latched dst; instr_ready SHALL be 1 from the first edge after release.

Structure
REQ-028 Opcode constants (0x0..0xF) and state encodings SHALL live in the shared CPU package used by EXE.
REQ-029 The register file SHALL be one sub-module, regfile4x8, with two read ports and one write port.

Verification
REQ-030 Write R1=0x05 via wb, byte 0x14 (ADD R1,R0) -> next cycle issue_valid=1, op=1, s1=0x05, s2=0x00, dst=1.
REQ-031 Bytes 0xF8, 0x7F -> no issue after first, then op=0xF, imm_out=0x7F, dst=2, wr_en_out=1.
REQ-032 ADD issued, then 0xA3 with zn_in=2'b10 -> instr_ready low one cycle, then br_taken=1, br_target=R3.
REQ-033 wb_en=1, wb_addr=0, wb_data=0xAA same cycle as byte 0x80 (MOV R0,R0) -> s2_out=0xAA.
REQ-034 rst_n low while in IMM -> outputs 0; next byte 0x7F decoded as instruction op=7 (IN).

Source files
------------

// File: rtl/decode_issue_pkg.sv
// Shared CPU definitions: opcode map, decode state encodings and opcode class helpers.
// Both the decode/issue stage and the execute stage use these.
package decode_issue_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_CMP   = 4'h6;
  localparam logic [3:0] OP_IN    = 4'h7;
  localparam logic [3:0] OP_MOV   = 4'h8;
  localparam logic [3:0] OP_BR    = 4'h9;
  localparam logic [3:0] OP_BRZ   = 4'hA;
  localparam logic [3:0] OP_BRN   = 4'hB;
  localparam logic [3:0] OP_RSV_C = 4'hC;
  localparam logic [3:0] OP_RSV_D = 4'hD;
  localparam logic [3:0] OP_OUT   = 4'hE;
  localparam logic [3:0] OP_LDI   = 4'hF;

  localparam logic [1:0] ST_DEC       = 2'd0;
  localparam logic [1:0] ST_IMM       = 2'd1;
  localparam logic [1:0] ST_FLAG_WAIT = 2'd2;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
  } instr_t;

  // Ops whose flags are still in flight in EXE during the cycle after they issue.
  function automatic logic sets_flags(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  function automatic logic issues_with_wb(input logic [3:0] op);
    return sets_flags(op) || (op == OP_IN) || (op == OP_MOV);
  endfunction

  function automatic logic issues_without_wb(input logic [3:0] op);
    return (op == OP_CMP) || (op == OP_OUT);
  endfunction

endpackage

// File: rtl/decode_issue_regfile.sv
// Four 8-bit registers, two combinational read ports and one write port.
// With FWD_EN set, a read of the register being written this cycle returns the new data.
module regfile4x8 #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [1:0] rd_addr_a,
  output logic [7:0] rd_data_a,
  input  logic [1:0] rd_addr_b,
  output logic [7:0] rd_data_b
);

  logic [3:0][7:0] regs_q;
  logic [3:0][7:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
    if (FWD_EN && wr_en && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end
    if (FWD_EN && wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: consumes instruction bytes, reads operands, issues ALU ops
// and resolves branches, stalling one cycle when a branch needs flags still in EXE.
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr_in,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       wb_en,
  input  logic [1:0] wb_addr,
  input  logic [7:0] wb_data,
  input  logic [1:0] zn_in,
  output logic [3:0] op_out,
  output logic [7:0] s1_out,
  output logic [7:0] s2_out,
  output logic [7:0] imm_out,
  output logic [1:0] dst_out,
  output logic       wr_en_out,
  output logic       issue_valid,
  output logic       br_taken,
  output logic [7:0] br_target
);

  instr_t     instr;
  logic       accept;
  logic       flag_hazard;
  logic       cond_met;
  logic [1:0] rd_addr_b;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;

  logic [1:0] state_q, state_d;
  logic [1:0] ldi_dst_q, ldi_dst_d;
  logic       br_is_z_q, br_is_z_d;
  logic [1:0] br_rb_q, br_rb_d;
  logic       ready_q, ready_d;
  logic [3:0] op_q, op_d;
  logic [7:0] s1_q, s1_d;
  logic [7:0] s2_q, s2_d;
  logic [7:0] imm_q, imm_d;
  logic [1:0] dst_q, dst_d;
  logic       wr_en_q, wr_en_d;
  logic       issue_q, issue_d;
  logic       br_taken_q, br_taken_d;
  logic [7:0] br_target_q, br_target_d;

  assign instr  = instr_t'(instr_in);
  assign accept = instr_valid && ready_q;

  // A parked conditional branch reads its target through port B using the saved rb.
  assign rd_addr_b = (state_q == ST_FLAG_WAIT) ? br_rb_q : instr.rb;

  regfile4x8 #(
    .FWD_EN(FWD_EN)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wb_en),
    .wr_addr  (wb_addr),
    .wr_data  (wb_data),
    .rd_addr_a(instr.ra),
    .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_b(rd_data_b)
  );

  always_comb begin
    flag_hazard = issue_q && sets_flags(op_q);
    cond_met    = (state_q == ST_FLAG_WAIT) ? (br_is_z_q ? zn_in[1] : zn_in[0])
                                            : ((instr.op == OP_BRZ) ? zn_in[1] : zn_in[0]);

    state_d     = state_q;
    ldi_dst_d   = ldi_dst_q;
    br_is_z_d   = br_is_z_q;
    br_rb_d     = br_rb_q;
    ready_d     = 1'b1;
    op_d        = op_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    imm_d       = imm_q;
    dst_d       = dst_q;
    wr_en_d     = wr_en_q;
    issue_d     = 1'b0;
    br_taken_d  = 1'b0;
    br_target_d = br_target_q;

    case (state_q)
      ST_DEC: begin
        if (accept) begin
          if (instr.op == OP_LDI) begin
            ldi_dst_d = instr.ra;
            state_d   = ST_IMM;
          end else if (issues_with_wb(instr.op) || issues_without_wb(instr.op)) begin
            issue_d = 1'b1;
            op_d    = instr.op;
            s1_d    = rd_data_a;
            s2_d    = rd_data_b;
            dst_d   = instr.ra;
            wr_en_d = issues_with_wb(instr.op);
          end else if (instr.op == OP_BR) begin
            br_taken_d  = 1'b1;
            br_target_d = rd_data_b;
            ready_d     = 1'b0;
          end else if ((instr.op == OP_BRZ) || (instr.op == OP_BRN)) begin
            if (flag_hazard) begin
              state_d   = ST_FLAG_WAIT;
              br_is_z_d = (instr.op == OP_BRZ);
              br_rb_d   = instr.rb;
              ready_d   = 1'b0;
            end else if (cond_met) begin
              br_taken_d  = 1'b1;
              br_target_d = rd_data_b;
              ready_d     = 1'b0;
            end
          end
        end
      end
      ST_IMM: begin
        if (accept) begin
          issue_d = 1'b1;
          op_d    = OP_LDI;
          imm_d   = instr_in;
          dst_d   = ldi_dst_q;
          wr_en_d = 1'b1;
          state_d = ST_DEC;
        end
      end
      ST_FLAG_WAIT: begin
        state_d = ST_DEC;
        if (cond_met) begin
          br_taken_d  = 1'b1;
          br_target_d = rd_data_b;
          ready_d     = 1'b0;
        end
      end
      default: begin
        state_d = ST_DEC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_DEC;
      ldi_dst_q   <= '0;
      br_is_z_q   <= 1'b0;
      br_rb_q     <= '0;
      ready_q     <= 1'b0;
      op_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      imm_q       <= '0;
      dst_q       <= '0;
      wr_en_q     <= 1'b0;
      issue_q     <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      state_q     <= state_d;
      ldi_dst_q   <= ldi_dst_d;
      br_is_z_q   <= br_is_z_d;
      br_rb_q     <= br_rb_d;
      ready_q     <= ready_d;
      op_q        <= op_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      imm_q       <= imm_d;
      dst_q       <= dst_d;
      wr_en_q     <= wr_en_d;
      issue_q     <= issue_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
    end
  end

  assign instr_ready = ready_q;
  assign op_out      = op_q;
  assign s1_out      = s1_q;
  assign s2_out      = s2_q;
  assign imm_out     = imm_q;
  assign dst_out     = dst_q;
  assign wr_en_out   = wr_en_q;
  assign issue_valid = issue_q;
  assign br_taken    = br_taken_q;
  assign br_target   = br_target_q;

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the decode rules.
module tb_decode_issue;

  localparam bit FWD_EN = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] instr_in;
  logic       instr_valid;
  logic       instr_ready;
  logic       wb_en;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic [1:0] zn_in;
  logic [3:0] op_out;
  logic [7:0] s1_out, s2_out, imm_out, br_target;
  logic [1:0] dst_out;
  logic       wr_en_out, issue_valid, br_taken;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_issue #(.FWD_EN(FWD_EN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_in   (instr_in),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .zn_in      (zn_in),
    .op_out     (op_out),
    .s1_out     (s1_out),
    .s2_out     (s2_out),
    .imm_out    (imm_out),
    .dst_out    (dst_out),
    .wr_en_out  (wr_en_out),
    .issue_valid(issue_valid),
    .br_taken   (br_taken),
    .br_target  (br_target)
  );

  // Reference model: architectural registers plus what the outputs should show next.
  logic [7:0] m_regs [4];
  logic       m_imm_pending, m_flag_pending, m_flag_z;
  logic [1:0] m_imm_dst, m_flag_rb;
  logic       e_ready, e_issue, e_wr, e_br;
  logic [3:0] e_op;
  logic [7:0] e_s1, e_s2, e_imm, e_tgt;
  logic [1:0] e_dst;

  function automatic logic [7:0] model_read(input logic [1:0] a, input logic we,
                                            input logic [1:0] wa, input logic [7:0] wd);
    if (FWD_EN && we && (wa == a)) return wd;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_imm_pending = 0; m_flag_pending = 0; m_flag_z = 0; m_imm_dst = 0; m_flag_rb = 0;
    e_ready = 0; e_issue = 0; e_wr = 0; e_br = 0; e_op = 0;
    e_s1 = 0; e_s2 = 0; e_imm = 0; e_tgt = 0; e_dst = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic we,
                            input logic [1:0] wa, input logic [7:0] wd, input logic [1:0] zn);
    logic [3:0] op;
    logic [1:0] ra, rb;
    logic prev_alu, acc, nready;
    op = b[7:4]; ra = b[3:2]; rb = b[1:0];
    prev_alu = e_issue && (e_op inside {[4'h1:4'h5]});
    acc = v && e_ready;
    e_issue = 0; e_br = 0; nready = 1;
    if (m_flag_pending) begin
      m_flag_pending = 0;
      if (m_flag_z ? zn[1] : zn[0]) begin
        e_br = 1; e_tgt = model_read(m_flag_rb, we, wa, wd); nready = 0;
      end
    end else if (acc) begin
      if (m_imm_pending) begin
        e_issue = 1; e_op = 4'hF; e_imm = b; e_dst = m_imm_dst; e_wr = 1; m_imm_pending = 0;
      end else if (op == 4'hF) begin
        m_imm_pending = 1; m_imm_dst = ra;
      end else if (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hE}) begin
        e_issue = 1; e_op = op; e_dst = ra;
        e_s1 = model_read(ra, we, wa, wd); e_s2 = model_read(rb, we, wa, wd);
        e_wr = !(op == 4'h6 || op == 4'hE);
      end else if (op == 4'h9) begin
        e_br = 1; e_tgt = model_read(rb, we, wa, wd); nready = 0;
      end else if (op == 4'hA || op == 4'hB) begin
        if (prev_alu) begin
          m_flag_pending = 1; m_flag_z = (op == 4'hA); m_flag_rb = rb; nready = 0;
        end else if ((op == 4'hA) ? zn[1] : zn[0]) begin
          e_br = 1; e_tgt = model_read(rb, we, wa, wd); nready = 0;
        end
      end
    end
    e_ready = nready;
    if (we) m_regs[wa] = wd;
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic we,
                       input logic [1:0] wa, input logic [7:0] wd, input logic [1:0] zn);
    instr_valid = v; instr_in = b; wb_en = we; wb_addr = wa; wb_data = wd; zn_in = zn;
    model_step(v, b, we, wa, wd, zn);
    @(posedge clk); #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0; instr_valid = 0; wb_en = 0; instr_in = 0; wb_addr = 0; wb_data = 0; zn_in = 0;
    model_reset();
    #2;
  endtask

  task automatic release_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    e_ready = 1;
  endtask

  task automatic test_reset();
    assert_reset();
    total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_issue got=%h exp=0", issue_valid); end
    total++; if (br_taken !== 1'b0) begin bad++; $display("[TB] FAIL rst_br got=%h exp=0", br_taken); end
    total++; if (instr_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready got=%h exp=0", instr_ready); end
    total++; if ({op_out, s1_out, s2_out, imm_out, dst_out, wr_en_out, br_target} !== 39'd0) begin
      bad++; $display("[TB] FAIL rst_outs got=%h exp=0", {op_out, s1_out, s2_out, imm_out, dst_out, wr_en_out, br_target});
    end
    release_reset();
    total++; if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_release_ready got=%h exp=1", instr_ready); end
  endtask

  task automatic test_add();
    assert_reset(); release_reset();
    drive(0, 8'h00, 1, 2'd1, 8'h05, 2'b00);
    drive(1, 8'h14, 0, 2'd0, 8'h00, 2'b00);
    total++; if (issue_valid !== 1'b1) begin bad++; $display("[TB] FAIL add_issue got=%h exp=1", issue_valid); end
    total++; if (op_out !== 4'h1) begin bad++; $display("[TB] FAIL add_op got=%h exp=1", op_out); end
    total++; if (s1_out !== 8'h05) begin bad++; $display("[TB] FAIL add_s1 got=%h exp=05", s1_out); end
    total++; if (s2_out !== 8'h00) begin bad++; $display("[TB] FAIL add_s2 got=%h exp=00", s2_out); end
    total++; if (dst_out !== 2'd1 || wr_en_out !== 1'b1) begin bad++; $display("[TB] FAIL add_dst got=%h/%h exp=1/1", dst_out, wr_en_out); end
    drive(0, 8'h00, 0, 2'd0, 8'h00, 2'b00);
    total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL add_pulse got=%h exp=0", issue_valid); end
  endtask

  task automatic test_loadimm();
    assert_reset(); release_reset();
    drive(1, 8'hF8, 0, 2'd0, 8'h00, 2'b00);
    total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL ldi_first got=%h exp=0", issue_valid); end
    drive(0, 8'h00, 0, 2'd0, 8'h00, 2'b00);
    drive(0, 8'h00, 0, 2'd0, 8'h00, 2'b00);
    total++; if (issue_valid !== 1'b0 || instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL ldi_wait got=%h/%h exp=0/1", issue_valid, instr_ready); end
    drive(1, 8'h7F, 0, 2'd0, 8'h00, 2'b00);
    total++; if (issue_valid !== 1'b1 || op_out !== 4'hF) begin bad++; $display("[TB] FAIL ldi_issue got=%h/%h exp=1/f", issue_valid, op_out); end
    total++; if (imm_out !== 8'h7F) begin bad++; $display("[TB] FAIL ldi_imm got=%h exp=7f", imm_out); end
    total++; if (dst_out !== 2'd2 || wr_en_out !== 1'b1) begin bad++; $display("[TB] FAIL ldi_dst got=%h/%h exp=2/1", dst_out, wr_en_out); end
  endtask

  task automatic test_flag_wait();
    assert_reset(); release_reset();
    drive(0, 8'h00, 1, 2'd3, 8'h3C, 2'b00);
    drive(1, 8'h14, 0, 2'd0, 8'h00, 2'b00);
    drive(1, 8'hA3, 0, 2'd0, 8'h00, 2'b10);
    total++; if (instr_ready !== 1'b0 || br_taken !== 1'b0 || issue_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL fw_stall got=%h/%h/%h exp=0/0/0", instr_ready, br_taken, issue_valid);
    end
    drive(0, 8'h00, 0, 2'd0, 8'h00, 2'b10);
    total++; if (br_taken !== 1'b1 || br_target !== 8'h3C) begin bad++; $display("[TB] FAIL fw_taken got=%h/%h exp=1/3c", br_taken, br_target); end
    total++; if (instr_ready !== 1'b0) begin bad++; $display("[TB] FAIL fw_br_ready got=%h exp=0", instr_ready); end
    drive(0, 8'h00, 0, 2'd0, 8'h00, 2'b00);
    total++; if (instr_ready !== 1'b1 || br_taken !== 1'b0) begin bad++; $display("[TB] FAIL fw_resume got=%h/%h exp=1/0", instr_ready, br_taken); end
  endtask

  task automatic test_branches();
    assert_reset(); release_reset();
    drive(0, 8'h00, 1, 2'd2, 8'h99, 2'b00);
    drive(1, 8'h92, 0, 2'd0, 8'h00, 2'b00);
    total++; if (br_taken !== 1'b1 || br_target !== 8'h99 || issue_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL br_uncond got=%h/%h/%h exp=1/99/0", br_taken, br_target, issue_valid);
    end
    drive(1, 8'hA2, 0, 2'd0, 8'h00, 2'b11);
    total++; if (br_taken !== 1'b0) begin bad++; $display("[TB] FAIL br_pulse got=%h exp=0", br_taken); end
    drive(1, 8'hA2, 0, 2'd0, 8'h00, 2'b01);
    total++; if (br_taken !== 1'b0 || instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL brz_not got=%h/%h exp=0/1", br_taken, instr_ready); end
    drive(1, 8'hB2, 0, 2'd0, 8'h00, 2'b01);
    total++; if (br_taken !== 1'b1 || br_target !== 8'h99) begin bad++; $display("[TB] FAIL brn_taken got=%h/%h exp=1/99", br_taken, br_target); end
  endtask

  task automatic test_no_wb_and_drop();
    assert_reset(); release_reset();
    drive(1, 8'h6D, 0, 2'd0, 8'h00, 2'b00);
    total++; if (issue_valid !== 1'b1 || op_out !== 4'h6 || wr_en_out !== 1'b0 || dst_out !== 2'd3) begin
      bad++; $display("[TB] FAIL cmp_issue got=%h/%h/%h/%h exp=1/6/0/3", issue_valid, op_out, wr_en_out, dst_out);
    end
    drive(1, 8'h05, 0, 2'd0, 8'h00, 2'b00);
    total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL drop_0 got=%h exp=0", issue_valid); end
    drive(1, 8'hC5, 0, 2'd0, 8'h00, 2'b00);
    total++; if (issue_valid !== 1'b0 || br_taken !== 1'b0) begin bad++; $display("[TB] FAIL drop_c got=%h/%h exp=0/0", issue_valid, br_taken); end
    drive(1, 8'hD5, 0, 2'd0, 8'h00, 2'b00);
    total++; if (issue_valid !== 1'b0) begin bad++; $display("[TB] FAIL drop_d got=%h exp=0", issue_valid); end
    drive(1, 8'hE4, 0, 2'd0, 8'h00, 2'b00);
    total++; if (issue_valid !== 1'b1 || op_out !== 4'hE || wr_en_out !== 1'b0) begin
      bad++; $display("[TB] FAIL out_issue got=%h/%h/%h exp=1/e/0", issue_valid, op_out, wr_en_out);
    end
  endtask

  task automatic test_forward();
    assert_reset(); release_reset();
    drive(1, 8'h80, 1, 2'd0, 8'hAA, 2'b00);
    total++; if (s2_out !== 8'hAA || s1_out !== 8'hAA) begin bad++; $display("[TB] FAIL fwd_s got=%h/%h exp=aa/aa", s1_out, s2_out); end
    total++; if (op_out !== 4'h8 || dst_out !== 2'd0 || wr_en_out !== 1'b1) begin
      bad++; $display("[TB] FAIL fwd_mov got=%h/%h/%h exp=8/0/1", op_out, dst_out, wr_en_out);
    end
  endtask

  task automatic test_reset_mid_imm();
    assert_reset(); release_reset();
    drive(0, 8'h00, 1, 2'd1, 8'h05, 2'b00);
    drive(1, 8'h14, 0, 2'd0, 8'h00, 2'b00);
    drive(1, 8'hF8, 0, 2'd0, 8'h00, 2'b00);
    assert_reset();
    total++; if (op_out !== 4'h0 || s1_out !== 8'h00 || dst_out !== 2'd0 || instr_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL rimm_clear got=%h/%h/%h/%h exp=0/0/0/0", op_out, s1_out, dst_out, instr_ready);
    end
    release_reset();
    total++; if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL rimm_ready got=%h exp=1", instr_ready); end
    drive(1, 8'h7F, 0, 2'd0, 8'h00, 2'b00);
    total++; if (issue_valid !== 1'b1 || op_out !== 4'h7 || dst_out !== 2'd3 || wr_en_out !== 1'b1) begin
      bad++; $display("[TB] FAIL rimm_in got=%h/%h/%h/%h exp=1/7/3/1", issue_valid, op_out, dst_out, wr_en_out);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    assert_reset(); release_reset();
    for (int n = 0; n < 600; n++) begin
      b = 8'($urandom);
      drive($urandom_range(0, 3) != 0, b, 1'($urandom), 2'($urandom), 8'($urandom), 2'($urandom));
      total++; if (instr_ready !== e_ready) begin bad++; $display("[TB] FAIL rnd_ready cyc=%0d got=%h exp=%h", n, instr_ready, e_ready); end
      total++; if (issue_valid !== e_issue) begin bad++; $display("[TB] FAIL rnd_issue cyc=%0d got=%h exp=%h", n, issue_valid, e_issue); end
      total++; if (br_taken !== e_br) begin bad++; $display("[TB] FAIL rnd_br cyc=%0d got=%h exp=%h", n, br_taken, e_br); end
      total++; if (issue_valid && br_taken) begin bad++; $display("[TB] FAIL rnd_both cyc=%0d got=1 exp=0", n); end
      if (e_issue) begin
        total++; if ({op_out, dst_out, wr_en_out} !== {e_op, e_dst, e_wr}) begin
          bad++; $display("[TB] FAIL rnd_ctl cyc=%0d got=%h exp=%h", n, {op_out, dst_out, wr_en_out}, {e_op, e_dst, e_wr});
        end
        if (e_op == 4'hF) begin
          total++; if (imm_out !== e_imm) begin bad++; $display("[TB] FAIL rnd_imm cyc=%0d got=%h exp=%h", n, imm_out, e_imm); end
        end else begin
          total++; if ({s1_out, s2_out} !== {e_s1, e_s2}) begin
            bad++; $display("[TB] FAIL rnd_src cyc=%0d got=%h exp=%h", n, {s1_out, s2_out}, {e_s1, e_s2});
          end
        end
      end
      if (e_br) begin
        total++; if (br_target !== e_tgt) begin bad++; $display("[TB] FAIL rnd_tgt cyc=%0d got=%h exp=%h", n, br_target, e_tgt); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 0; instr_in = 0; wb_en = 0; wb_addr = 0; wb_data = 0; zn_in = 0;
    model_reset();
    #3;
    test_reset();
    test_add();
    test_loadimm();
    test_flag_wait();
    test_branches();
    test_no_wb_and_drop();
    test_forward();
    test_reset_mid_imm();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
